// File: rtl/wb_pkg.sv
// Shared writeback definitions: default sizing and the queued-result record.
package wb_pkg;

   localparam int WB_N     = 32;
   localparam int WB_BITS  = 64;
   localparam int WB_DEPTH = 4;
   localparam int WB_RW    = $clog2(WB_N);

   typedef struct packed {
      logic               valid;
      logic [WB_RW-1:0]   rd;
      logic [WB_BITS-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Memory-result queue with kill-by-destination; cleared entries still occupy a slot
// and drain without producing a write.
module wb_fifo
   import wb_pkg::*;
#(
   parameter type entry_t = wb_entry_t,
   parameter int  RW      = WB_RW,
   parameter int  DEPTH   = WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   push_entry,
   input  logic                     pop,
   input  logic                     kill,
   input  logic [RW-1:0]            kill_rd,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{valid: 1'b0, rd: {RW{1'b0}}, data: '0};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && (mem_r[i].rd == kill_rd)) begin
               mem_r[i].valid <= 1'b0;
            end
         end
         if (push) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/wb_port_ctrl.sv
// Register-bank write-port arbiter: single-cycle ALU results versus queued memory
// results, with WAW kill, stall/violation detection and operand forwarding.
module wb_port_ctrl
   import wb_pkg::*;
#(
   parameter int N     = WB_N,
   parameter int Bits  = WB_BITS,
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [$clog2(N)-1:0]  alu_rd,
   input  logic [Bits-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [$clog2(N)-1:0]  mem_rd,
   input  logic [Bits-1:0]       mem_data,
   output logic [$clog2(N)-1:0]  ptr_wr,
   output logic [Bits-1:0]       data_wr,
   output logic                  wr_en,
   output logic                  stall,
   output logic                  err,
   input  logic [$clog2(N)-1:0]  ptr_rd_1,
   input  logic [$clog2(N)-1:0]  ptr_rd_2,
   output logic                  fwd_hit_1,
   output logic                  fwd_hit_2,
   output logic [Bits-1:0]       fwd_data_1,
   output logic [Bits-1:0]       fwd_data_2
);

   localparam int RW = $clog2(N);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic            valid;
      logic [RW-1:0]   rd;
      logic [Bits-1:0] data;
   } entry_t;

   entry_t          head_s;
   entry_t          push_entry_s;
   logic [CW-1:0]   count_s;
   logic            full_s;
   logic            empty_s;
   logic            push_s;
   logic            pop_s;
   logic            kill_s;
   logic            sel_valid_s;
   logic [RW-1:0]   sel_rd_s;
   logic [Bits-1:0] sel_data_s;
   logic            mem_ready_s;

   logic [RW-1:0]   ptr_wr_r;
   logic [Bits-1:0] data_wr_r;
   logic            wr_en_r;
   logic            err_r;

   assign full_s      = (count_s == CW'(DEPTH));
   assign empty_s     = (count_s == {CW{1'b0}});
   assign mem_ready_s = !rst && !full_s;
   assign push_s      = mem_valid && mem_ready_s && (mem_rd != {RW{1'b0}});

   // A same-cycle memory result to the ALU's rd is older, so it enters already dead.
   assign push_entry_s = '{valid: !(kill_s && (mem_rd == alu_rd)), rd: mem_rd, data: mem_data};

   // Write-port arbitration: a full queue must drain before the ALU may write again.
   always_comb begin
      pop_s       = 1'b0;
      kill_s      = 1'b0;
      sel_valid_s = 1'b0;
      sel_rd_s    = {RW{1'b0}};
      sel_data_s  = {Bits{1'b0}};
      if (full_s) begin
         pop_s       = 1'b1;
         sel_valid_s = head_s.valid;
         sel_rd_s    = head_s.rd;
         sel_data_s  = head_s.data;
      end else if (alu_valid) begin
         if (alu_rd != {RW{1'b0}}) begin
            kill_s      = 1'b1;
            sel_valid_s = 1'b1;
            sel_rd_s    = alu_rd;
            sel_data_s  = alu_data;
         end else begin
            sel_valid_s = 1'b0;
         end
      end else if (!empty_s) begin
         pop_s       = 1'b1;
         sel_valid_s = head_s.valid;
         sel_rd_s    = head_s.rd;
         sel_data_s  = head_s.data;
      end else begin
         pop_s = 1'b0;
      end
   end

   wb_fifo #(
      .entry_t (entry_t),
      .RW      (RW),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .kill       (kill_s),
      .kill_rd    (alu_rd),
      .head       (head_s),
      .count      (count_s)
   );

   // Registered write port and sticky violation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_wr_r  <= {RW{1'b0}};
         data_wr_r <= {Bits{1'b0}};
         wr_en_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         wr_en_r <= sel_valid_s;
         if (sel_valid_s) begin
            ptr_wr_r  <= sel_rd_s;
            data_wr_r <= sel_data_s;
         end
         err_r <= err_r | (alu_valid & full_s);
      end
   end

   assign ptr_wr    = ptr_wr_r;
   assign data_wr   = data_wr_r;
   assign wr_en     = wr_en_r;
   assign err       = err_r;
   assign mem_ready = mem_ready_s;
   assign stall     = full_s && !rst;

   assign fwd_hit_1  = !rst && wr_en_r && (ptr_rd_1 == ptr_wr_r) && (ptr_rd_1 != {RW{1'b0}});
   assign fwd_hit_2  = !rst && wr_en_r && (ptr_rd_2 == ptr_wr_r) && (ptr_rd_2 != {RW{1'b0}});
   assign fwd_data_1 = fwd_hit_1 ? data_wr_r : {Bits{1'b0}};
   assign fwd_data_2 = fwd_hit_2 ? data_wr_r : {Bits{1'b0}};

endmodule
